collider_scan_scheduler: RTL and testbench
==========================================

// Module: collider_scan_scheduler
// PURPOSE
//   Sequences the shared object-collider datapath once per game tick: sweeps object slots
//   0..OBJECT_AMOUNT-1, issues one check per ready object, waits for the result, and
//   aggregates player/object collisions into a per-tick hit mask and a ground summary.
//   Sits between the game-manager tick and the multi-object collider; feeds player position.
// PARAMETERS
//   OBJECT_AMOUNT  20  number of object slots scanned per tick
//   IDX_W          5   width of slot index; must satisfy 2**IDX_W > OBJECT_AMOUNT
//   TIMEOUT        15  max cycles waited for col_valid after accept; >=2
// PORTS
//   clk                 in   1              system clock
//   clk_reset           in   1              synchronous reset, active-high
//   start               in   1              1-cycle tick pulse: begin a scan
//   object_ready_state  in   OBJECT_AMOUNT  slot-live mask, sampled on accepted start
//   col_req             out  1              request a check of slot col_idx
//   col_idx             out  IDX_W          slot index under check
//   col_ready           in   1              collider accepts col_req this cycle
//   col_valid           in   1              result valid, 1-cycle pulse
//   col_hit             in   1              player overlaps object
//   col_ground          in   1              object is a standable ground for player
//   col_ground_h        in   10             object top y when col_ground
//   busy                out  1              scan in progress (state != IDLE)
//   done                out  1              1-cycle pulse: results updated
//   hit_mask            out  OBJECT_AMOUNT  per-slot hit of last completed scan
//   is_ground           out  1              any ground result in last scan
//   ground_h            out  10             min col_ground_h of last scan; 10'h3FF if none
//   overrun             out  1              sticky: start seen while not IDLE
//   timeout_err         out  1              sticky: a check timed out
// BEHAVIOUR
//   Reset: state IDLE, col_req=0, col_idx=0, busy=0, done=0, hit_mask=0, is_ground=0,
//     ground_h=10'h3FF, overrun=0, timeout_err=0, internal accumulators cleared.
//     Reset mid-scan aborts; col_req low the cycle after reset asserted; no done pulse.
//   States: IDLE, SEEK, ISSUE, WAIT, DONE.
//   IDLE:  start=1 -> latch mask, idx=0, clear acc (mask=0, gnd=0, gh=3FF), clear overrun
//          and timeout_err -> SEEK.
//   SEEK:  idx==OBJECT_AMOUNT -> DONE; mask[idx]=0 -> idx+1 (1 cycle per skipped slot);
//          else -> ISSUE.
//   ISSUE: col_req=1, col_idx=idx held stable; col_ready=1 -> WAIT, timer=0.
//   WAIT:  col_req=0. col_valid=1 -> acc_mask[idx]|=col_hit; if col_ground: acc_gnd=1,
//          acc_gh=min(acc_gh,col_ground_h) (unsigned, ties keep value); idx+1 -> SEEK.
//          Else timer+1; timer==TIMEOUT-1 with no valid -> timeout_err=1, slot counts no
//          hit, idx+1 -> SEEK. col_valid on the timeout cycle is still accepted (valid wins).
//   DONE:  done=1 for exactly this cycle; outputs hit_mask/is_ground/ground_h committed on
//          the edge entering DONE (valid while done=1) -> IDLE. busy=0 in DONE? no: busy=1.
//   Outputs hold previous scan results throughout a scan; never partially updated.
//   col_valid outside WAIT ignored. start outside IDLE (incl. DONE) ignored, sets overrun.
//   Mask changes after accepted start have no effect on the current scan.
//   idx counter is IDX_W bits; never exceeds OBJECT_AMOUNT.
//   Latency: start in cycle 0, all-zero mask -> done=1 in cycle OBJECT_AMOUNT+2.
//   Per live slot with col_ready=1 and valid L cycles after accept: 2+L cycles.
// TESTING
//   1 mask=0, start@c0 -> no col_req; done=1 exactly at c22; hit_mask=0, ground_h=3FF.
//   2 mask bits 3,7,19; collider ready, valid 3 cycles later; hit on 7, ground on 3 (h=200)
//     and 19 (h=150) -> col_idx sequence 3,7,19; hit_mask=0x00080; is_ground=1; ground_h=150.
//   3 col_ready held low 10 cycles on slot 0 -> col_req and col_idx=0 stable all 10 cycles,
//     no advance; result then accepted normally.
//   4 slot 5 live, col_valid never returns -> WAIT exits after 15 cycles, timeout_err=1,
//     hit_mask[5]=0, scan completes; next accepted start clears timeout_err.
//   5 start pulsed mid-scan and on DONE cycle -> ignored, overrun=1, results unaffected.
//   6 clk_reset during WAIT -> next cycle IDLE, all outputs at reset values, no done pulse.

Source files
------------

// File: rtl/collider_scan_scheduler_if.sv
// rtl/collider_scan_scheduler_if.sv - request/result bus between scan scheduler and object collider
//
// Purpose: carries one collision-check request (slot index) from the scheduler to
// the shared collider and the single-cycle result pulse back.
// Signals:
//   col_req       scheduler -> collider  request a check of slot col_idx
//   col_idx       scheduler -> collider  slot index under check (IDX_W bits)
//   col_ready     collider -> scheduler  request accepted this cycle
//   col_valid     collider -> scheduler  result valid, 1-cycle pulse
//   col_hit       collider -> scheduler  player overlaps object
//   col_ground    collider -> scheduler  object is standable ground
//   col_ground_h  collider -> scheduler  object top y when col_ground
// Modports: master = scheduler side, slave = collider side.
`timescale 1ns/1ps
interface collider_scan_scheduler_if #(
    parameter int IDX_W = 5
) ();
    logic             col_req;
    logic [IDX_W-1:0] col_idx;
    logic             col_ready;
    logic             col_valid;
    logic             col_hit;
    logic             col_ground;
    logic [9:0]       col_ground_h;

    modport master (
        output col_req,
        output col_idx,
        input  col_ready,
        input  col_valid,
        input  col_hit,
        input  col_ground,
        input  col_ground_h
    );

    modport slave (
        input  col_req,
        input  col_idx,
        output col_ready,
        output col_valid,
        output col_hit,
        output col_ground,
        output col_ground_h
    );
endinterface

// File: rtl/collider_scan_scheduler.sv
// rtl/collider_scan_scheduler.sv - per-tick sweep of object slots through the shared collider
//
// Purpose: on each accepted start pulse, walks slots 0..OBJECT_AMOUNT-1, issues one
// collider check per live slot, waits (bounded) for the result, and aggregates the
// per-slot hit mask plus the lowest standable ground height. Results are committed
// atomically when the sweep finishes and held until the next sweep completes.
// Ports:
//   clk, clk_reset      clock, synchronous active-high reset
//   start               1-cycle tick pulse, accepted only in IDLE
//   object_ready_state  slot-live mask, latched on accepted start
//   col                 collider request/result bus (master side)
//   busy                scan in progress (any state but IDLE)
//   done                1-cycle pulse, results below just updated
//   hit_mask            per-slot hit of last completed scan
//   is_ground           any ground result in last completed scan
//   ground_h            min ground height of last scan, 10'h3FF if none
//   overrun             sticky: start seen outside IDLE, cleared on accepted start
//   timeout_err         sticky: a check timed out, cleared on accepted start
`timescale 1ns/1ps
module collider_scan_scheduler #(
    parameter int OBJECT_AMOUNT = 20,
    parameter int IDX_W         = 5,
    parameter int TIMEOUT       = 15
) (
    input  logic                     clk,
    input  logic                     clk_reset,
    input  logic                     start,
    input  logic [OBJECT_AMOUNT-1:0] object_ready_state,
    collider_scan_scheduler_if.master col,
    output logic                     busy,
    output logic                     done,
    output logic [OBJECT_AMOUNT-1:0] hit_mask,
    output logic                     is_ground,
    output logic [9:0]               ground_h,
    output logic                     overrun,
    output logic                     timeout_err
);
    // Timer counts 0..TIMEOUT-1 inside WAIT.
    localparam int               TMR_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(OBJECT_AMOUNT);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [9:0]       GH_NONE  = 10'h3FF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEEK,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                   state;
    logic [OBJECT_AMOUNT-1:0] scan_mask;
    logic [OBJECT_AMOUNT-1:0] acc_mask;
    logic                     acc_gnd;
    logic [9:0]               acc_gh;
    logic [IDX_W-1:0]         idx;
    logic [TMR_W-1:0]         timer;
    logic                     req_q;

    // idx is stable for the whole ISSUE state, so it doubles as the request index.
    assign col.col_req = req_q;
    assign col.col_idx = idx;

    always_ff @(posedge clk) begin
        if (clk_reset) begin
            state       <= S_IDLE;
            scan_mask   <= '0;
            acc_mask    <= '0;
            acc_gnd     <= 1'b0;
            acc_gh      <= GH_NONE;
            idx         <= '0;
            timer       <= '0;
            req_q       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hit_mask    <= '0;
            is_ground   <= 1'b0;
            ground_h    <= GH_NONE;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            // A tick arriving while the previous sweep is still running (including
            // its DONE cycle) is dropped and flagged; the IDLE branch clears it.
            if (start && state != S_IDLE) begin
                overrun <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        scan_mask   <= object_ready_state;
                        idx         <= '0;
                        acc_mask    <= '0;
                        acc_gnd     <= 1'b0;
                        acc_gh      <= GH_NONE;
                        overrun     <= 1'b0;
                        timeout_err <= 1'b0;
                        busy        <= 1'b1;
                        state       <= S_SEEK;
                    end
                end

                S_SEEK: begin
                    if (idx == IDX_END) begin
                        // Commit the whole scan at once so consumers never see a
                        // partially accumulated result.
                        hit_mask  <= acc_mask;
                        is_ground <= acc_gnd;
                        ground_h  <= acc_gh;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end else if (!scan_mask[idx]) begin
                        idx <= idx + IDX_ONE;
                    end else begin
                        req_q <= 1'b1;
                        state <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (col.col_ready) begin
                        req_q <= 1'b0;
                        timer <= '0;
                        state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    // A result on the last allowed cycle still counts.
                    if (col.col_valid) begin
                        acc_mask[idx] <= acc_mask[idx] | col.col_hit;
                        if (col.col_ground) begin
                            acc_gnd <= 1'b1;
                            if (col.col_ground_h < acc_gh) begin
                                acc_gh <= col.col_ground_h;
                            end
                        end
                        idx   <= idx + IDX_ONE;
                        state <= S_SEEK;
                    end else if (timer == TMR_LAST) begin
                        timeout_err <= 1'b1;
                        idx         <= idx + IDX_ONE;
                        state       <= S_SEEK;
                    end else begin
                        timer <= timer + TMR_ONE;
                    end
                end

                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    req_q <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_collider_scan_scheduler.sv
// tb/tb_collider_scan_scheduler.sv - scoreboard bench for collider_scan_scheduler
`timescale 1ns/1ps
module tb_collider_scan_scheduler;
    localparam int N       = 20;
    localparam int IDX_W   = 5;
    localparam int TIMEOUT = 15;

    typedef struct {
        logic [N-1:0] m;
        logic         g;
        logic [9:0]   h;
        logic         to;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         clk_reset;
    logic         start;
    logic [N-1:0] object_ready_state;
    logic         busy, done, is_ground, overrun, timeout_err;
    logic [N-1:0] hit_mask;
    logic [9:0]   ground_h;

    collider_scan_scheduler_if #(.IDX_W(IDX_W)) col_if ();

    collider_scan_scheduler #(.OBJECT_AMOUNT(N), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
        .clk                (clk),
        .clk_reset          (clk_reset),
        .start              (start),
        .object_ready_state (object_ready_state),
        .col                (col_if),
        .busy               (busy),
        .done               (done),
        .hit_mask           (hit_mask),
        .is_ground          (is_ground),
        .ground_h           (ground_h),
        .overrun            (overrun),
        .timeout_err        (timeout_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Per-slot collider behaviour: ready delay, result latency (0 = never answers).
    int         rdy_dly[N];
    int         lat[N];
    bit         hit_s[N];
    bit         gnd_s[N];
    logic [9:0] gh_s[N];

    exp_t exp_q[$];
    int   exp_idx[$];
    logic [N-1:0] last_m = '0;
    logic         last_g = 1'b0;
    logic [9:0]   last_h = 10'h3FF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Collider model: answers each request according to the slot tables.
    int phase = 0;
    int cnt   = 0;
    int cur   = 0;
    always @(negedge clk) begin
        col_if.col_ready    = 1'b0;
        col_if.col_valid    = 1'b0;
        col_if.col_hit      = 1'b0;
        col_if.col_ground   = 1'b0;
        col_if.col_ground_h = 10'h0;
        if (clk_reset) begin
            phase = 0;
        end else begin
            if (phase == 0 && col_if.col_req) begin
                cur = int'(col_if.col_idx);
                if (exp_idx.size() == 0) begin
                    chk("unexpected_req", 32'(cur), 32'hFFFF);
                    cur = 0;
                end else begin
                    chk("col_idx_seq", 32'(cur), 32'(exp_idx.pop_front()));
                end
                cnt   = rdy_dly[cur];
                phase = 1;
            end else if (phase == 1) begin
                chk("issue_hold", {col_if.col_req, 26'(col_if.col_idx)}, {1'b1, 26'(cur)});
            end
            if (phase == 1) begin
                if (cnt == 0) begin
                    col_if.col_ready = 1'b1;
                    cnt   = lat[cur];
                    phase = (lat[cur] == 0) ? 0 : 2;
                end else begin
                    cnt--;
                end
            end else if (phase == 2) begin
                cnt--;
                if (cnt == 0) begin
                    col_if.col_valid    = 1'b1;
                    col_if.col_hit      = hit_s[cur];
                    col_if.col_ground   = gnd_s[cur];
                    col_if.col_ground_h = gh_s[cur];
                    phase = 0;
                end
            end else if (!busy && $urandom_range(0, 3) == 0) begin
                // Stray result while idle must be ignored.
                col_if.col_valid    = 1'b1;
                col_if.col_hit      = 1'b1;
                col_if.col_ground   = 1'b1;
                col_if.col_ground_h = 10'h001;
            end
        end
    end

    // Monitor: pops the scoreboard on every done, otherwise results must hold.
    always @(negedge clk) begin
        exp_t e;
        if (clk_reset) begin
            last_m = '0;
            last_g = 1'b0;
            last_h = 10'h3FF;
        end else if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'h0);
            end else begin
                e = exp_q.pop_front();
                chk("hit_mask", 32'(hit_mask), 32'(e.m));
                chk("is_ground", 32'(is_ground), 32'(e.g));
                chk("ground_h", 32'(ground_h), 32'(e.h));
                chk("timeout_err", 32'(timeout_err), 32'(e.to));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                last_m = e.m;
                last_g = e.g;
                last_h = e.h;
            end
        end else begin
            chk("results_hold", {hit_mask, is_ground, ground_h}, {last_m, last_g, last_h});
        end
    end

    task automatic clear_slots();
        for (int i = 0; i < N; i++) begin
            rdy_dly[i] = 0;
            lat[i]     = 1;
            hit_s[i]   = 1'b0;
            gnd_s[i]   = 1'b0;
            gh_s[i]    = 10'h0;
        end
    endtask

    task automatic rand_slots();
        for (int i = 0; i < N; i++) begin
            rdy_dly[i] = $urandom_range(0, 3);
            lat[i]     = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TIMEOUT);
            hit_s[i]   = 1'($urandom);
            gnd_s[i]   = 1'($urandom);
            gh_s[i]    = ($urandom_range(0, 1) == 0) ? 10'($urandom) : 10'($urandom_range(300, 302));
        end
    endtask

    task automatic run_scan(input logic [N-1:0] m, input bit mid, input bit endst);
        exp_t e;
        int   extra;
        bit   got;
        extra = 0;
        e.m = '0; e.g = 1'b0; e.h = 10'h3FF; e.to = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (m[i]) begin
                exp_idx.push_back(i);
                extra += 1 + rdy_dly[i] + ((lat[i] == 0) ? TIMEOUT : lat[i]);
                if (lat[i] == 0) begin
                    e.to = 1'b1;
                end else begin
                    if (hit_s[i]) e.m[i] = 1'b1;
                    if (gnd_s[i]) begin
                        e.g = 1'b1;
                        if (gh_s[i] < e.h) e.h = gh_s[i];
                    end
                end
            end
        end
        @(negedge clk);
        object_ready_state = m;
        start = 1'b1;
        e.cyc = cyc + N + 2 + extra;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        object_ready_state = N'($urandom);
        got = 1'b0;
        for (int k = 0; k < 3000 && !got; k++) begin
            if (done) begin
                got = 1'b1;
            end else begin
                start = (mid && k == 4);
                @(negedge clk);
            end
        end
        if (!got) begin
            chk("done_wait", 32'h0, 32'h1);
            exp_q.delete();
            exp_idx.delete();
        end
        if (endst) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after", 32'(busy), 32'h0);
        chk("overrun", 32'(overrun), 32'(mid | endst));
        chk("timeout_sticky", 32'(timeout_err), 32'(e.to));
        chk("idx_consumed", 32'(exp_idx.size()), 32'h0);
        object_ready_state = '0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_col_req"}, 32'(col_if.col_req), 32'h0);
        chk({tag, "_col_idx"}, 32'(col_if.col_idx), 32'h0);
        chk({tag, "_hit_mask"}, 32'(hit_mask), 32'h0);
        chk({tag, "_is_ground"}, 32'(is_ground), 32'h0);
        chk({tag, "_ground_h"}, 32'(ground_h), 32'h3FF);
        chk({tag, "_overrun"}, 32'(overrun), 32'h0);
        chk({tag, "_timeout_err"}, 32'(timeout_err), 32'h0);
    endtask

    initial begin
        #1000000;
        n_bad++;
        $display("FAIL watchdog: got running expected finished (cycle %0d)", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        logic [N-1:0] m;
        clk_reset = 1'b1;
        start = 1'b0;
        object_ready_state = '0;
        col_if.col_ready = 1'b0;
        col_if.col_valid = 1'b0;
        col_if.col_hit = 1'b0;
        col_if.col_ground = 1'b0;
        col_if.col_ground_h = 10'h0;
        clear_slots();
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        clk_reset = 1'b0;

        // Empty mask: pure sweep latency.
        run_scan('0, 1'b0, 1'b0);

        // Slots 3, 7, 19 with fixed results.
        clear_slots();
        lat[3] = 3; lat[7] = 3; lat[19] = 3;
        hit_s[7] = 1'b1;
        gnd_s[3] = 1'b1; gh_s[3] = 10'd200;
        gnd_s[19] = 1'b1; gh_s[19] = 10'd150;
        m = '0; m[3] = 1'b1; m[7] = 1'b1; m[19] = 1'b1;
        run_scan(m, 1'b0, 1'b0);

        // Collider stalls slot 0 for 10 cycles.
        clear_slots();
        rdy_dly[0] = 10; lat[0] = 2; hit_s[0] = 1'b1;
        run_scan(N'(1), 1'b0, 1'b0);

        // Slot 5 never answers, then a clean scan clears the error.
        clear_slots();
        lat[5] = 0; hit_s[5] = 1'b1;
        run_scan(N'(1 << 5), 1'b0, 1'b0);
        run_scan('0, 1'b0, 1'b0);

        // Result arriving on the last allowed cycle is kept.
        clear_slots();
        lat[9] = TIMEOUT; hit_s[9] = 1'b1; gnd_s[9] = 1'b1; gh_s[9] = 10'd7;
        run_scan(N'(1 << 9), 1'b0, 1'b0);

        // Overrun: start mid-scan and on the done cycle.
        rand_slots();
        run_scan(N'($urandom), 1'b1, 1'b1);

        // Reset while waiting on a result.
        clear_slots();
        lat[2] = 0;
        exp_idx.push_back(2);
        @(negedge clk);
        object_ready_state = N'(1 << 2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 32'h1);
        chk("pre_reset_overrun", 32'(overrun), 32'h1);
        clk_reset = 1'b1;
        @(negedge clk);
        clk_reset = 1'b0;
        check_reset_vals("midscan_reset");
        repeat (30) @(negedge clk);
        chk("post_reset_idle", 32'(busy), 32'h0);

        // Randomized scans.
        for (int t = 0; t < 25; t++) begin
            rand_slots();
            m = (t % 5 == 0) ? '1 : N'($urandom & ($urandom | $urandom));
            run_scan(m, (t % 7 == 3), (t % 6 == 1));
        end

        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
